mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
Multicycle MIPS control unit. It sequences each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK states, and drives the datapath enables and mux selects. It issues ALUOp to the ALU using the `ALU_*` codes from ctrl_encode_def.v, and consumes the ALU Zero flag to resolve branches. This block is the initiator end of the ALU interface.

Parameters:
- RA_IDX, 5'd31, register index that JAL writes its link address to.

Ports:
- clk, input, 1, system clock; rising edge.
- rstn, input, 1, synchronous reset, active-low.
- Op, input, 6, IR[31:26]. Valid from DECODE onward.
- Funct, input, 6, IR[5:0].
- Zero, input, 1, ALU Zero flag.
- PCWrite, output, 1, PC register write enable.
- IRWrite, output, 1, IR write enable.
- IorD, output, 1, memory address select. 0 = PC, 1 = ALUOut.
- MemRead, output, 1, data memory read strobe.
- MemWrite, output, 1, data memory write strobe.
- RegWrite, output, 1, GPR write enable.
- GPRSel, output, 2, GPR write destination. 00 = rd, 01 = rt, 10 = RA_IDX.
- WDSel, output, 2, GPR write data select. 00 = ALUOut, 01 = MDR, 10 = PC.
- ALUSrcA, output, 2, ALU A operand. 00 = PC, 01 = reg A, 10 = {27'b0, shamt}.
- ALUSrcB, output, 2, ALU B operand. 00 = reg B, 01 = 32'd4, 10 = ext(imm), 11 = ext(imm)<<2.
- EXTOp, output, 1, immediate extension. 1 = sign-extend, 0 = zero-extend.
- NPCSel, output, 2, next-PC source. 00 = ALU C, 01 = ALUOut, 10 = {PC[31:28], IR[25:0], 2'b0}, 11 = reg A.
- ALUOp, output, 5, ALU operation code (`ALU_*`).
- Illegal, output, 1, one-cycle pulse on an unsupported opcode or funct.
- State, output, 4, current state, for debug.

Behaviour:
- State register: 4 bits. Outputs are decoded combinationally from State, Op and Funct. Any output not listed for a state is 0; ALUOp defaults to `ALU_NOP`.
- Reset:
  - rstn=0 at a clk edge sets State=FETCH (0).
  - While rstn=0, all enables (PCWrite, IRWrite, MemRead, MemWrite, RegWrite) and Illegal are forced to 0.
  - Reset mid-instruction abandons the instruction; nothing partial is written after the edge.
- FETCH (0):
  - Outputs: IorD=0, MemRead=1, IRWrite=1, ALUSrcA=00, ALUSrcB=01, `ALU_ADD`, NPCSel=00, PCWrite=1.
  - Next state: DECODE.
- DECODE (1):
  - Outputs: ALUSrcA=00, ALUSrcB=11, EXTOp=1, `ALU_ADD` (computes the branch target into ALUOut).
  - Next state by Op:
    - 0x00 with funct 0x08 -> JR.
    - 0x00 with another legal funct -> EXEC_R.
    - 0x02 or 0x03 -> JUMP.
    - 0x04 to 0x07 -> BRANCH.
    - 0x08, 0x09, 0x0A, 0x0C to 0x0F -> EXEC_I.
    - 0x23 or 0x2B -> MEM_ADDR.
    - Anything else (including Op 0x00 with an illegal funct) -> FETCH with Illegal=1 for that cycle.
- EXEC_R (2):
  - ALUSrcB=00. ALUSrcA=10 for funct 0x00, 0x02 and 0x03; otherwise 01.
  - Funct to ALUOp: 0x20/0x21 ADD; 0x22 SUB; 0x24 AND; 0x25 OR; 0x26 XOR; 0x27 NOR; 0x2A SLT; 0x2B SLTU; 0x00 SLL; 0x02 SRL; 0x03 SRA.
  - Next state: ALU_WB, with GPRSel=00.
- EXEC_I (3):
  - ALUSrcA=01, ALUSrcB=10.
  - Op to ALUOp and EXTOp: 0x08/0x09 ADD with EXTOp=1; 0x0A SLT with EXTOp=1; 0x0C ANDI, 0x0D ORI, 0x0E XORI, each with EXTOp=0; 0x0F LUI.
  - Next state: ALU_WB, with GPRSel=01.
- ALU_WB (8):
  - Outputs: RegWrite=1, WDSel=00, GPRSel as selected above.
  - Next state: FETCH.
- MEM_ADDR (4):
  - Outputs: ALUSrcA=01, ALUSrcB=10, EXTOp=1, `ALU_ADD`.
  - Next state: MEM_RD if Op=0x23, MEM_WR if Op=0x2B.
- MEM_RD (5): IorD=1, MemRead=1. Next state: MEM_WB.
- MEM_WB (6): RegWrite=1, WDSel=01, GPRSel=01. Next state: FETCH.
- MEM_WR (7): IorD=1, MemWrite=1. Next state: FETCH.
- BRANCH (9):
  - Outputs: ALUSrcA=01, ALUSrcB=00, NPCSel=01, PCWrite=Zero.
  - Op to ALUOp: 0x04 `ALU_SUB`; 0x05 `ALU_BNE`; 0x06 `ALU_BLEZ`; 0x07 `ALU_BGTZ`.
  - Taken if and only if Zero=1 in this cycle.
  - Next state: FETCH.
- JUMP (10):
  - Outputs: NPCSel=10, PCWrite=1.
  - For Op=0x03 also RegWrite=1, WDSel=10, GPRSel=10. PC already holds PC+4 at this point.
  - Next state: FETCH.
- JR (11): NPCSel=11, PCWrite=1. Next state: FETCH.
- Unused states 12 to 15: all outputs 0, next state FETCH.
- Latencies in cycles:
  - R-type and I-type ALU: 4.
  - LW: 5.
  - SW: 4.
  - Branch: 3.
  - J, JAL, JR: 3.
  - Illegal: 2.

Test Plan:
- Reset: rstn=0 for 2 cycles in any state -> State=0 and every enable 0. After release, PCWrite=1, IRWrite=1, ALUOp=`ALU_ADD`, ALUSrcB=01.
- ADD (Op=0x00, Funct=0x20) -> state sequence 0,1,2,8,0. In state 8: RegWrite=1, GPRSel=00, WDSel=00. SLL (Funct=0x00) shows ALUSrcA=10 in state 2.
- LW (Op=0x23) -> state sequence 0,1,4,5,6,0. In state 5: MemRead=1, IorD=1. In state 6: RegWrite=1, WDSel=01. SW (Op=0x2B) -> 0,1,4,7,0 with MemWrite=1 only in state 7.
- BEQ (Op=0x04): Zero=1 gives PCWrite=1 and NPCSel=01 in state 9; Zero=0 gives PCWrite=0. BGTZ (Op=0x07) shows ALUOp=`ALU_BGTZ` in state 9.
- JAL (Op=0x03) -> state sequence 0,1,10,0. In state 10: PCWrite=1, NPCSel=10, RegWrite=1, GPRSel=10, WDSel=10. JR (Op=0x00, Funct=0x08) -> state 11 with NPCSel=11.
- Op=0x3F -> Illegal=1 for exactly one cycle in state 1, then State=0, and no RegWrite, MemWrite or branch-stage PCWrite occurs. Asserting rstn=0 during state 5 -> State=0 next cycle and no RegWrite.

Source files
------------

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle MIPS control unit: state sequencer and datapath control decode
module mc_ctrl #(
   parameter logic [4:0] RA_IDX = 5'd31
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Zero,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic [1:0] GPRSel,
   output logic [1:0] WDSel,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       EXTOp,
   output logic [1:0] NPCSel,
   output logic [4:0] ALUOp,
   output logic       Illegal,
   output logic [3:0] State
);

   localparam logic [4:0] ALU_NOP  = 5'd0;
   localparam logic [4:0] ALU_ADD  = 5'd1;
   localparam logic [4:0] ALU_SUB  = 5'd2;
   localparam logic [4:0] ALU_AND  = 5'd3;
   localparam logic [4:0] ALU_OR   = 5'd4;
   localparam logic [4:0] ALU_XOR  = 5'd5;
   localparam logic [4:0] ALU_NOR  = 5'd6;
   localparam logic [4:0] ALU_SLT  = 5'd7;
   localparam logic [4:0] ALU_SLTU = 5'd8;
   localparam logic [4:0] ALU_SLL  = 5'd9;
   localparam logic [4:0] ALU_SRL  = 5'd10;
   localparam logic [4:0] ALU_SRA  = 5'd11;
   localparam logic [4:0] ALU_LUI  = 5'd12;
   localparam logic [4:0] ALU_BNE  = 5'd13;
   localparam logic [4:0] ALU_BLEZ = 5'd14;
   localparam logic [4:0] ALU_BGTZ = 5'd15;

   // A link register of $zero would silently drop the return address, so JAL is refused then.
   localparam bit LINK_OK = (RA_IDX != 5'd0);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_EXEC_I   = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_MEM_WB   = 4'd6,
      S_MEM_WR   = 4'd7,
      S_ALU_WB   = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP     = 4'd10,
      S_JR       = 4'd11
   } state_t;

   state_t state_q, state_d;
   logic   funct_ok;

   always_ff @(posedge clk) begin
      if (!rstn) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   assign State = state_q;

   always_comb begin
      funct_ok = 1'b0;
      case (Funct)
         6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
         6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03: funct_ok = 1'b1;
         default:                           funct_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = S_FETCH;
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      GPRSel   = 2'b00;
      WDSel    = 2'b00;
      ALUSrcA  = 2'b00;
      ALUSrcB  = 2'b00;
      EXTOp    = 1'b0;
      NPCSel   = 2'b00;
      ALUOp    = ALU_NOP;
      Illegal  = 1'b0;

      case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            IRWrite = 1'b1;
            ALUSrcB = 2'b01;
            ALUOp   = ALU_ADD;
            PCWrite = 1'b1;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcB = 2'b11;
            EXTOp   = 1'b1;
            ALUOp   = ALU_ADD;
            case (Op)
               6'h00: begin
                  if (Funct == 6'h08) state_d = S_JR;
                  else if (funct_ok)  state_d = S_EXEC_R;
                  else                Illegal = 1'b1;
               end
               6'h02:                 state_d = S_JUMP;
               6'h03: begin
                  if (LINK_OK)        state_d = S_JUMP;
                  else                Illegal = 1'b1;
               end
               6'h04, 6'h05, 6'h06, 6'h07:
                                      state_d = S_BRANCH;
               6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F:
                                      state_d = S_EXEC_I;
               6'h23, 6'h2B:          state_d = S_MEM_ADDR;
               default:               Illegal = 1'b1;
            endcase
         end
         S_EXEC_R: begin
            ALUSrcA = (Funct == 6'h00 || Funct == 6'h02 || Funct == 6'h03) ? 2'b10 : 2'b01;
            case (Funct)
               6'h20, 6'h21: ALUOp = ALU_ADD;
               6'h22:        ALUOp = ALU_SUB;
               6'h24:        ALUOp = ALU_AND;
               6'h25:        ALUOp = ALU_OR;
               6'h26:        ALUOp = ALU_XOR;
               6'h27:        ALUOp = ALU_NOR;
               6'h2A:        ALUOp = ALU_SLT;
               6'h2B:        ALUOp = ALU_SLTU;
               6'h00:        ALUOp = ALU_SLL;
               6'h02:        ALUOp = ALU_SRL;
               6'h03:        ALUOp = ALU_SRA;
               default:      ALUOp = ALU_NOP;
            endcase
            state_d = S_ALU_WB;
         end
         S_EXEC_I: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            case (Op)
               6'h08, 6'h09: begin ALUOp = ALU_ADD; EXTOp = 1'b1; end
               6'h0A:        begin ALUOp = ALU_SLT; EXTOp = 1'b1; end
               6'h0C:        ALUOp = ALU_AND;
               6'h0D:        ALUOp = ALU_OR;
               6'h0E:        ALUOp = ALU_XOR;
               6'h0F:        ALUOp = ALU_LUI;
               default:      ALUOp = ALU_NOP;
            endcase
            state_d = S_ALU_WB;
         end
         // IR is held through the instruction, so Op still tells R-type (rd) from I-type (rt).
         S_ALU_WB: begin
            RegWrite = 1'b1;
            GPRSel   = (Op == 6'h00) ? 2'b00 : 2'b01;
            state_d  = S_FETCH;
         end
         S_MEM_ADDR: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            EXTOp   = 1'b1;
            ALUOp   = ALU_ADD;
            if (Op == 6'h23)      state_d = S_MEM_RD;
            else if (Op == 6'h2B) state_d = S_MEM_WR;
            else                  state_d = S_FETCH;
         end
         S_MEM_RD: begin
            IorD    = 1'b1;
            MemRead = 1'b1;
            state_d = S_MEM_WB;
         end
         S_MEM_WB: begin
            RegWrite = 1'b1;
            WDSel    = 2'b01;
            GPRSel   = 2'b01;
            state_d  = S_FETCH;
         end
         S_MEM_WR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA = 2'b01;
            NPCSel  = 2'b01;
            PCWrite = Zero;
            case (Op)
               6'h04:   ALUOp = ALU_SUB;
               6'h05:   ALUOp = ALU_BNE;
               6'h06:   ALUOp = ALU_BLEZ;
               6'h07:   ALUOp = ALU_BGTZ;
               default: ALUOp = ALU_NOP;
            endcase
            state_d = S_FETCH;
         end
         S_JUMP: begin
            NPCSel  = 2'b10;
            PCWrite = 1'b1;
            if (Op == 6'h03) begin
               RegWrite = 1'b1;
               WDSel    = 2'b10;
               GPRSel   = 2'b10;
            end
            state_d = S_FETCH;
         end
         S_JR: begin
            NPCSel  = 2'b11;
            PCWrite = 1'b1;
            state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase

      // Reset gates every side effect so an abandoned instruction writes nothing.
      if (!rstn) begin
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         RegWrite = 1'b0;
         Illegal  = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - directed self-checking bench for mc_ctrl
module tb_mc_ctrl;

   localparam logic [4:0] ALU_ADD  = 5'd1;
   localparam logic [4:0] ALU_SUB  = 5'd2;
   localparam logic [4:0] ALU_OR   = 5'd4;
   localparam logic [4:0] ALU_SLL  = 5'd9;
   localparam logic [4:0] ALU_BGTZ = 5'd15;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [5:0] Op = 6'h00;
   logic [5:0] Funct = 6'h00;
   logic       Zero = 1'b0;
   logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, EXTOp, Illegal;
   logic [1:0] GPRSel, WDSel, ALUSrcA, ALUSrcB, NPCSel;
   logic [4:0] ALUOp;
   logic [3:0] State;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   mc_ctrl #(.RA_IDX(5'd31)) dut (
      .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .RegWrite(RegWrite), .GPRSel(GPRSel), .WDSel(WDSel),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .EXTOp(EXTOp), .NPCSel(NPCSel),
      .ALUOp(ALUOp), .Illegal(Illegal), .State(State)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      // reset held across two edges
      rstn = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rst_state", State, 0);
      chk("rst_pcwrite", PCWrite, 0);
      chk("rst_irwrite", IRWrite, 0);
      chk("rst_memread", MemRead, 0);
      chk("rst_regwrite", RegWrite, 0);
      rstn = 1'b1;
      #1;
      chk("fetch_pcwrite", PCWrite, 1);
      chk("fetch_irwrite", IRWrite, 1);
      chk("fetch_aluop", ALUOp, ALU_ADD);
      chk("fetch_srcb", ALUSrcB, 2'b01);

      // ADD
      Op = 6'h00; Funct = 6'h20;
      tick(); chk("add_s1", State, 1);
      chk("dec_srcb", ALUSrcB, 2'b11);
      chk("dec_extop", EXTOp, 1);
      tick(); chk("add_s2", State, 2);
      chk("add_srca", ALUSrcA, 2'b01);
      chk("add_aluop", ALUOp, ALU_ADD);
      tick(); chk("add_s8", State, 8);
      chk("add_regwrite", RegWrite, 1);
      chk("add_gprsel", GPRSel, 2'b00);
      chk("add_wdsel", WDSel, 2'b00);
      tick(); chk("add_s0", State, 0);

      // SLL
      Funct = 6'h00;
      tick(); tick(); chk("sll_s2", State, 2);
      chk("sll_srca", ALUSrcA, 2'b10);
      chk("sll_aluop", ALUOp, ALU_SLL);
      tick(); tick(); chk("sll_s0", State, 0);

      // ORI
      Op = 6'h0D;
      tick(); tick(); chk("ori_s3", State, 3);
      chk("ori_aluop", ALUOp, ALU_OR);
      chk("ori_extop", EXTOp, 0);
      chk("ori_srcb", ALUSrcB, 2'b10);
      tick(); chk("ori_s8", State, 8);
      chk("ori_gprsel", GPRSel, 2'b01);
      tick(); chk("ori_s0", State, 0);

      // LW
      Op = 6'h23;
      tick(); tick(); chk("lw_s4", State, 4);
      tick(); chk("lw_s5", State, 5);
      chk("lw_memread", MemRead, 1);
      chk("lw_iord", IorD, 1);
      tick(); chk("lw_s6", State, 6);
      chk("lw_regwrite", RegWrite, 1);
      chk("lw_wdsel", WDSel, 2'b01);
      tick(); chk("lw_s0", State, 0);

      // SW
      Op = 6'h2B;
      tick(); tick(); chk("sw_s4", State, 4);
      chk("sw_memwrite4", MemWrite, 0);
      tick(); chk("sw_s7", State, 7);
      chk("sw_memwrite7", MemWrite, 1);
      chk("sw_regwrite7", RegWrite, 0);
      tick(); chk("sw_s0", State, 0);
      chk("sw_memwrite0", MemWrite, 0);

      // BEQ taken and not taken
      Op = 6'h04; Zero = 1'b1;
      tick(); tick(); chk("beq_s9", State, 9);
      chk("beq_t_pcwrite", PCWrite, 1);
      chk("beq_npcsel", NPCSel, 2'b01);
      chk("beq_aluop", ALUOp, ALU_SUB);
      tick(); chk("beq_s0", State, 0);
      Zero = 1'b0;
      tick(); tick(); chk("beq_nt_s9", State, 9);
      chk("beq_nt_pcwrite", PCWrite, 0);
      tick();

      // BGTZ
      Op = 6'h07;
      tick(); tick(); chk("bgtz_aluop", ALUOp, ALU_BGTZ);
      tick();

      // JAL
      Op = 6'h03;
      tick(); chk("jal_s1", State, 1);
      tick(); chk("jal_s10", State, 10);
      chk("jal_pcwrite", PCWrite, 1);
      chk("jal_npcsel", NPCSel, 2'b10);
      chk("jal_regwrite", RegWrite, 1);
      chk("jal_gprsel", GPRSel, 2'b10);
      chk("jal_wdsel", WDSel, 2'b10);
      tick(); chk("jal_s0", State, 0);

      // J has no link write
      Op = 6'h02;
      tick(); tick(); chk("j_regwrite", RegWrite, 0);
      tick();

      // JR
      Op = 6'h00; Funct = 6'h08;
      tick(); tick(); chk("jr_s11", State, 11);
      chk("jr_npcsel", NPCSel, 2'b11);
      chk("jr_pcwrite", PCWrite, 1);
      tick(); chk("jr_s0", State, 0);

      // illegal opcode
      Op = 6'h3F;
      chk("ill_fetch", Illegal, 0);
      tick(); chk("ill_s1", State, 1);
      chk("ill_pulse", Illegal, 1);
      chk("ill_regwrite1", RegWrite, 0);
      tick(); chk("ill_s0", State, 0);
      chk("ill_cleared", Illegal, 0);
      chk("ill_regwrite0", RegWrite, 0);
      chk("ill_memwrite0", MemWrite, 0);

      // illegal funct
      Op = 6'h00; Funct = 6'h01;
      tick(); chk("illf_pulse", Illegal, 1);
      tick(); chk("illf_s0", State, 0);

      // reset during MEM_RD
      Op = 6'h23;
      tick(); tick(); tick(); chk("rstmid_s5", State, 5);
      rstn = 1'b0;
      #1;
      chk("rstmid_memread", MemRead, 0);
      tick(); chk("rstmid_s0", State, 0);
      chk("rstmid_regwrite", RegWrite, 0);
      rstn = 1'b1;
      #1;
      chk("rstmid_fetch", PCWrite, 1);
      tick(); chk("rstmid_s1", State, 1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
